add_arbiter: RTL
================

# add_arbiter

Round-robin arbiter that shares the processor's single 32-bit adder among up to NREQ requesters (PC+4 increment, branch-target calculation, load/store address generation, ALU). Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle and registers the sum. It returns the sum to the granted requester with per-requester response valid/ready backpressure.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- RR_INIT, 0, requester index that holds top priority after reset; legal range 0..NREQ-1.

- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk.
- req_valid  input  NREQ  bit i: requester i presents operands.
- req_ready  output  NREQ  bit i: requester i's operands accepted this cycle; at most one bit high.
- req_a  input  NREQ*32  operand A; requester i at bits [32*i+31:32*i].
- req_b  input  NREQ*32  operand B; same packing as req_a.
- rsp_valid  output  NREQ  one-hot or zero; bit i: rsp_data belongs to requester i.
- rsp_ready  input  NREQ  bit i: requester i consumes the response.
- rsp_data  output  32  registered sum.
- rsp_carry  output  1  carry-out of the registered sum; present only with ADD_ARB_CARRY_EN.

## Operation
- One output register holds out_valid, out_id, out_data and out_carry (the last only with the macro).
- Drain condition: out_valid && rsp_ready[out_id].
- Free condition: !out_valid || drain.
- Grant:
  - Evaluated combinationally each cycle.
  - Search starts at pointer ptr and walks ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - The first requester with req_valid set wins.
  - req_ready[g] = free && req_valid[g]. All other req_ready bits are 0.
- Accept (req_ready[g] high):
  - out_data <= req_a[g] + req_b[g], mod 2^32.
  - out_id <= g; out_valid <= 1.
  - ptr <= (g+1) mod NREQ.
- Drain without accept: out_valid <= 0. ptr is unchanged.
- Drain with accept in the same cycle: the register reloads with the new sum; no bubble.
- No requester valid: ptr is unchanged.
- rsp_valid[i] = out_valid && (out_id == i).
- rsp_data and rsp_carry hold their value while out_valid=1 and the response is not drained.
- Requesters must hold req_a and req_b stable while req_valid=1 and req_ready=0. The arbiter does not check this.
- States:
  - EMPTY (out_valid=0): any valid request is accepted.
  - FULL (out_valid=1):
    - Accepts only in a cycle where the response drains.
    - Stays FULL while rsp_ready[out_id]=0. All req_ready are 0 during the stall.
- A requester may keep req_valid high across its own outstanding response. It is re-granted only when its turn comes and the register is free.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_carry=0.
  - Internal: out_id=0, ptr=RR_INIT.
- Latency: operands accepted at edge N, rsp_valid high after edge N.
- Throughput: one add per cycle when responses are consumed immediately.
- Fairness: every continuously valid requester is granted within NREQ accepts.
- Reset mid-operation clears any pending response. Nothing is replayed.
- req_ready depends combinationally on req_valid and rsp_ready. No output depends combinationally on req_a or req_b.

## Configuration
- ADD_ARB_CARRY_EN defined:
  - Sum is computed 33 bits wide.
  - out_carry <= bit 32 of the sum, registered alongside out_data.
  - rsp_carry is exported.
- ADD_ARB_CARRY_EN undefined:
  - rsp_carry port and its register are absent.
  - Sum is 32 bits and the carry is discarded.

## Test plan
- Reset with all req_valid=1, then release:
  - All outputs are 0 during reset.
  - First grant goes to requester 0 (RR_INIT=0).
  - rsp_valid=4'b0001 one cycle after the grant.
- Single request, requester 2, a=0x0000_0005, b=0x0000_0007:
  - req_ready=4'b0100.
  - Next cycle: rsp_valid=4'b0100, rsp_data=0x0000_000C.
- All four requesters valid continuously, all rsp_ready=1:
  - Grant order is 0,1,2,3,0,... with one accept per cycle and no bubbles.
- Backpressure, requester 1:
  - Requester 1 response pending with rsp_ready[1]=0 for 3 cycles while requester 3 is valid.
  - req_ready stays 0 and rsp_data stays stable.
  - In the cycle rsp_ready[1] rises, requester 3 is accepted; its response appears the next cycle.
- Wrap-around with ADD_ARB_CARRY_EN, a=0xFFFF_FFFF, b=0x0000_0002:
  - rsp_data=0x0000_0001, rsp_carry=1.
  - Without the macro: rsp_data=0x0000_0001 and no carry port exists.
- Async reset asserted while a response is pending:
  - rsp_valid drops to 0 immediately, without waiting for a clock edge.
  - After release, ptr=RR_INIT and no stale response is emitted.

Source files
------------

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among NREQ requesters, with a registered sum.
// Define ADD_ARB_CARRY_EN to register the carry-out and export it on rsp_carry.
module add_arbiter #(
  parameter int NREQ    = 4,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_data
`ifdef ADD_ARB_CARRY_EN
  ,
  output logic              rsp_carry
`endif
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [IDW-1:0]  grant;
  logic            found;
  logic            drain;
  logic            free;
  logic            accept;
`ifdef ADD_ARB_CARRY_EN
  logic            out_carry_q, out_carry_d;
  logic [32:0]     sum;
`else
  logic [31:0]     sum;
`endif

  // Walk ptr, ptr+1, ... with wrap; the first valid requester wins.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  // Gating with rst_n keeps req_ready low while reset is held.
  assign drain  = (state_q == FULL) && rsp_ready[out_id_q];
  assign free   = rst_n && ((state_q == EMPTY) || drain);
  assign accept = free && found;

`ifdef ADD_ARB_CARRY_EN
  assign sum = {1'b0, req_a[32*grant +: 32]} + {1'b0, req_b[32*grant +: 32]};
`else
  assign sum = req_a[32*grant +: 32] + req_b[32*grant +: 32];
`endif

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (accept) req_ready[grant] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state_q == FULL) && (out_id_q == IDW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    out_id_d   = out_id_q;
    out_data_d = out_data_q;
    ptr_d      = ptr_q;
`ifdef ADD_ARB_CARRY_EN
    out_carry_d = out_carry_q;
`endif
    if (accept) begin
      state_d    = FULL;
      out_id_d   = grant;
      out_data_d = sum[31:0];
      ptr_d      = IDW'((int'(grant) + 1) % NREQ);
`ifdef ADD_ARB_CARRY_EN
      out_carry_d = sum[32];
`endif
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_id_q   <= '0;
      out_data_q <= '0;
      ptr_q      <= IDW'(RR_INIT);
`ifdef ADD_ARB_CARRY_EN
      out_carry_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      out_id_q   <= out_id_d;
      out_data_q <= out_data_d;
      ptr_q      <= ptr_d;
`ifdef ADD_ARB_CARRY_EN
      out_carry_q <= out_carry_d;
`endif
    end
  end

  assign rsp_data = out_data_q;
`ifdef ADD_ARB_CARRY_EN
  assign rsp_carry = out_carry_q;
`endif

endmodule
